// File: rtl/fetch_predict_stage_if.sv
// Fetch-stage bus bundle: redirect/resolve feedback from the backend, the
// instruction-memory address/data pair, and the registered decode outputs.
//   master : the fetch stage (drives the IM address and the decode outputs)
//   slave  : the environment (decode/backend/instruction memory)
interface fetch_predict_stage_if;
  logic        WANT_FREEZE;
  logic        Redirect_IN;
  logic [31:0] Redirect_PC_IN;
  logic        Resolve_Valid_IN;
  logic [31:0] Resolve_PC_IN;
  logic [31:0] Resolve_Target_IN;
  logic        Resolve_Taken_IN;
  logic [31:0] Instr_address_2IM;
  logic [31:0] Instr1_fIM;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr1_PC_OUT;
  logic [31:0] Instr1_PC_Plus4_OUT;
  logic        Branch_prediction_OUT;

  modport master (
    input  WANT_FREEZE, Redirect_IN, Redirect_PC_IN,
    input  Resolve_Valid_IN, Resolve_PC_IN, Resolve_Target_IN, Resolve_Taken_IN,
    input  Instr1_fIM,
    output Instr_address_2IM,
    output Instr1_OUT, Instr1_PC_OUT, Instr1_PC_Plus4_OUT, Branch_prediction_OUT
  );

  modport slave (
    output WANT_FREEZE, Redirect_IN, Redirect_PC_IN,
    output Resolve_Valid_IN, Resolve_PC_IN, Resolve_Target_IN, Resolve_Taken_IN,
    output Instr1_fIM,
    input  Instr_address_2IM,
    input  Instr1_OUT, Instr1_PC_OUT, Instr1_PC_Plus4_OUT, Branch_prediction_OUT
  );
endinterface

// File: rtl/fetch_predict_stage.sv
// Instruction-fetch stage with a direct-mapped BTB (2-bit saturating counters).
// Holds the PC, drives it combinationally to instruction memory, and registers
// instruction / PC / PC+4 / prediction bit for decode one cycle later.
// Ports:
//   CLK   : clock, all state on rising edge
//   RESET : synchronous active-high reset, beats every other input
//   bus   : fetch_predict_stage_if.master (redirect, resolve, IM, decode outputs)
module fetch_predict_stage #(
  parameter int          BTB_IDX_W = 4,
  parameter logic [31:0] RESET_PC  = 32'hBFC00000
) (
  input  logic                         CLK,
  input  logic                         RESET,
  fetch_predict_stage_if.master        bus
);

  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W   = 30 - BTB_IDX_W;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [31:0]      tgt;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t btb [ENTRIES];

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic        pred_q;

  // ---------------- lookup (current PC) ----------------
  logic [BTB_IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0]     lk_tag;
  btb_entry_t           lk_ent;
  logic                 lk_hit;
  logic                 predict_taken;

  assign lk_idx        = pc[BTB_IDX_W+1:2];
  assign lk_tag        = pc[31:BTB_IDX_W+2];
  assign lk_ent        = btb[lk_idx];
  assign lk_hit        = lk_ent.vld && (lk_ent.tag == lk_tag);
  assign predict_taken = lk_hit && lk_ent.ctr[1];
  assign pc_plus4      = pc + 32'd4;
  assign next_pc       = predict_taken ? lk_ent.tgt : pc_plus4;

  // ---------------- update (resolved branch) ----------------
  logic [BTB_IDX_W-1:0] ru_idx;
  logic [TAG_W-1:0]     ru_tag;
  btb_entry_t           ru_ent;
  logic                 ru_hit;
  logic [1:0]           ru_ctr_nxt;

  assign ru_idx = bus.Resolve_PC_IN[BTB_IDX_W+1:2];
  assign ru_tag = bus.Resolve_PC_IN[31:BTB_IDX_W+2];
  assign ru_ent = btb[ru_idx];
  assign ru_hit = ru_ent.vld && (ru_ent.tag == ru_tag);

  always_comb begin
    ru_ctr_nxt = ru_ent.ctr;
    if (bus.Resolve_Taken_IN) begin
      if (ru_ent.ctr != 2'd3) ru_ctr_nxt = ru_ent.ctr + 2'd1;
    end else begin
      if (ru_ent.ctr != 2'd0) ru_ctr_nxt = ru_ent.ctr - 2'd1;
    end
  end

  // Word-offset bits of the resolve PC play no part in indexing or tagging.
  logic unused_bits;
  assign unused_bits = ^bus.Resolve_PC_IN[1:0];

  // BTB writes are independent of freeze/redirect. Lookup reads the array
  // combinationally, so a same-cycle update of the looked-up index is only
  // visible from the next cycle on.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
    end else if (bus.Resolve_Valid_IN) begin
      if (ru_hit) begin
        btb[ru_idx].ctr <= ru_ctr_nxt;
        if (bus.Resolve_Taken_IN) btb[ru_idx].tgt <= bus.Resolve_Target_IN;
      end else if (bus.Resolve_Taken_IN) begin
        // Allocate weakly-taken; replaces any aliasing entry at this index.
        btb[ru_idx] <= '{vld: 1'b1, tag: ru_tag, tgt: bus.Resolve_Target_IN, ctr: 2'b10};
      end
    end
  end

  // ---------------- PC and decode registers ----------------
  // Redirect outranks freeze: a flush must not be swallowed by a stall.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc      <= RESET_PC;
      instr_q <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      pred_q  <= 1'b0;
    end else if (bus.Redirect_IN) begin
      pc      <= bus.Redirect_PC_IN;
      instr_q <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      pred_q  <= 1'b0;
    end else if (!bus.WANT_FREEZE) begin
      pc      <= next_pc;
      instr_q <= bus.Instr1_fIM;
      pc_q    <= pc;
      pc4_q   <= pc_plus4;
      pred_q  <= predict_taken;
    end
  end

  assign bus.Instr_address_2IM     = pc;
  assign bus.Instr1_OUT            = instr_q;
  assign bus.Instr1_PC_OUT         = pc_q;
  assign bus.Instr1_PC_Plus4_OUT   = pc4_q;
  assign bus.Branch_prediction_OUT = pred_q;

endmodule
